shifter_self_test: RTL and testbench



---
 rtl/shifter_self_test.sv | 97 +++++++++
 tb/tb_shifter_self_test.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shifter_self_test.sv
// shifter_self_test: 8-bit barrel shifter BIST with per-group pass flags (optional SHIFTER_ERR_COUNT_EN adds err_count)
module shifter_core (
  input  logic [7:0] data,
  input  logic [2:0] amt,
  input  logic [1:0] op,
  output logic [7:0] out
);
  logic [15:0] sx, rx;
  assign sx = {{8{data[7]}}, data} >> amt;
  assign rx = {data, data} << amt;
  // op select: SLL, SRL, SRA (sign-extended window), ROL (doubled word window)
  always_comb out = op == 2'b00 ? data << amt : op == 2'b01 ? data >> amt : op == 2'b10 ? sx[7:0] : rx[15:8];
endmodule

module shifter_self_test #(
  parameter logic [7:0] PAT_A = 8'hA5,
  parameter logic [7:0] PAT_B = 8'h3C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] tests,
  input  logic       fault_en,
  output logic [2:0] Test_report,
`ifdef SHIFTER_ERR_COUNT_EN
  output logic [7:0] err_count,
`endif
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [2:0] sel, rem, pass, amt;
  logic [4:0] idx;
  logic [1:0] grp, op;
  logic [7:0] data, dut_out, ref_out;
  logic launch, active, last, miss;
  shifter_core u_core (.data(data), .amt(amt), .op(op), .out(dut_out));
  // reference: each output bit picks its source bit by index arithmetic
  genvar i;
  for (i = 0; i < 8; i++) begin : g_ref
    assign ref_out[i] = op == 2'b11 ? data[3'(i) - amt] :
                        op == 2'b00 ? (amt <= 3'(i) ? data[3'(i) - amt] : 1'b0) :
                        (4'(i) + 4'(amt) < 4'd8 ? data[3'(i) + amt] : op == 2'b10 & data[7]);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // next state: RUN lingers one cycle after the last vector before DONE
  always_comb next = state == IDLE ? (launch ? RUN : IDLE) : state == RUN ? (rem == 3'b000 ? DONE : RUN) : IDLE;
  // vector decode: lowest remaining group is current, so unselected groups cost nothing
  always_comb begin
    launch = state == IDLE && tests != 3'b000 && tests != sel;
    active = state == RUN && rem != 3'b000;
    grp = rem[0] ? 2'd0 : rem[1] ? 2'd1 : 2'd2;
    op = grp == 2'd0 ? 2'b00 : grp == 2'd2 ? 2'b11 : {idx[4], ~idx[4]};
    data = idx[3] ? PAT_B : PAT_A;
    amt = idx[2:0];
    last = grp == 2'd1 ? idx == 5'd31 : idx == 5'd15;
    miss = active && (dut_out ^ {7'b0, fault_en}) != ref_out;
  end
  // sequencer datapath and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel <= '0;
      rem <= '0;
      idx <= '0;
      pass <= '0;
      Test_report <= '0;
      done <= 1'b0;
    end else begin
      if (tests == 3'b000) sel <= '0;
      if (launch) begin
        sel <= tests;
        rem <= tests;
        idx <= '0;
        pass <= tests;
        Test_report <= '0;
        done <= 1'b0;
      end
      if (active) begin
        if (miss) pass[grp] <= 1'b0;
        if (last) rem[grp] <= 1'b0;
        idx <= last ? 5'd0 : idx + 5'd1;
      end
      if (state == RUN && rem == 3'b000) begin
        Test_report <= pass;
        done <= 1'b1;
      end
    end
`ifdef SHIFTER_ERR_COUNT_EN
  // saturating mismatch counter, cleared at launch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_count <= '0;
    else if (launch) err_count <= '0;
    else if (miss && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
endmodule

// File: tb/tb_shifter_self_test.sv
// tb_shifter_self_test: directed self-checking bench for shifter_self_test
module tb_shifter_self_test;
  logic clk = 0, rst_n = 0, fault_en = 0;
  logic [2:0] tests = 3'b000;
  logic [2:0] Test_report;
  logic done;
`ifdef SHIFTER_ERR_COUNT_EN
  logic [7:0] err_count;
`endif
  logic [7:0] c_data, c_out;
  logic [2:0] c_amt;
  logic [1:0] c_op;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  shifter_self_test dut (
    .clk(clk), .rst_n(rst_n), .tests(tests), .fault_en(fault_en),
    .Test_report(Test_report),
`ifdef SHIFTER_ERR_COUNT_EN
    .err_count(err_count),
`endif
    .done(done)
  );

  shifter_core u_probe (.data(c_data), .amt(c_amt), .op(c_op), .out(c_out));

  logic [1:0] v_op   [12] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00};
  logic [2:0] v_amt  [12] = '{3'd3, 3'd2, 3'd2, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7};
  logic [7:0] v_data [12] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 8'hA5};
  logic [7:0] v_exp  [12] = '{8'h28, 8'h29, 8'hE9, 8'h4B, 8'hC3, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h80};

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic start_run(input logic [2:0] t, input logic f, output logic d0, output int lat);
    @(negedge clk);
    tests = 3'b000;
    @(negedge clk);
    @(negedge clk);
    tests = t;
    fault_en = f;
    @(posedge clk);
    #1 d0 = done;
    wait_done(lat);
  endtask

  task automatic test_reset;
    rst_n = 0;
    #12;
    checks++;
    if (Test_report !== 3'b000) begin errors++; $display("FAIL reset_report: got %b want 000", Test_report); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_core;
    for (int k = 0; k < 12; k++) begin
      c_op = v_op[k];
      c_amt = v_amt[k];
      c_data = v_data[k];
      #1;
      checks++;
      if (c_out !== v_exp[k]) begin
        errors++;
        $display("FAIL core_%0d op=%b amt=%0d data=%h: got %h want %h", k, c_op, c_amt, c_data, c_out, v_exp[k]);
      end
    end
  endtask

  task automatic test_sll;
    logic d0;
    int lat;
    start_run(3'b001, 1'b0, d0, lat);
    checks++;
    if (lat != 17) begin errors++; $display("FAIL sll_latency: got %0d want 17", lat); end
    checks++;
    if (Test_report !== 3'b001) begin errors++; $display("FAIL sll_report: got %b want 001", Test_report); end
  endtask

  task automatic test_all;
    logic d0;
    int lat;
    start_run(3'b111, 1'b0, d0, lat);
    checks++;
    if (lat != 65) begin errors++; $display("FAIL all_latency: got %0d want 65", lat); end
    checks++;
    if (Test_report !== 3'b111) begin errors++; $display("FAIL all_report: got %b want 111", Test_report); end
  endtask

  task automatic test_fault;
    logic d0;
    int lat;
    start_run(3'b111, 1'b1, d0, lat);
    checks++;
    if (lat != 65) begin errors++; $display("FAIL fault_latency: got %0d want 65", lat); end
    checks++;
    if (Test_report !== 3'b000) begin errors++; $display("FAIL fault_report: got %b want 000", Test_report); end
`ifdef SHIFTER_ERR_COUNT_EN
    checks++;
    if (err_count !== 8'd64) begin errors++; $display("FAIL fault_err_count: got %0d want 64", err_count); end
`endif
    fault_en = 0;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    @(negedge clk);
    tests = 3'b000;
    @(negedge clk);
    @(negedge clk);
    tests = 3'b010;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++;
    if (Test_report !== 3'b000) begin errors++; $display("FAIL midrst_report: got %b want 000", Test_report); end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    wait_done(lat);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL midrst_rerun_latency: got %0d want 33", lat); end
    checks++;
    if (Test_report !== 3'b010) begin errors++; $display("FAIL midrst_rerun_report: got %b want 010", Test_report); end
  endtask

  task automatic test_change_during_run;
    int lat;
    @(negedge clk);
    tests = 3'b000;
    @(negedge clk);
    @(negedge clk);
    tests = 3'b001;
    @(posedge clk);
    repeat (3) @(negedge clk);
    tests = 3'b110;
    wait_done(lat);
    checks++;
    if (lat != 15) begin errors++; $display("FAIL change_latency: got %0d want 15", lat); end
    checks++;
    if (Test_report !== 3'b001) begin errors++; $display("FAIL change_report: got %b want 001", Test_report); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL change_relaunch_done: got %b want 0", done); end
    wait_done(lat);
    checks++;
    if (lat != 49) begin errors++; $display("FAIL change_relaunch_latency: got %0d want 49", lat); end
    checks++;
    if (Test_report !== 3'b110) begin errors++; $display("FAIL change_relaunch_report: got %b want 110", Test_report); end
  endtask

  task automatic test_hold_relaunch;
    logic d0;
    int lat;
    start_run(3'b100, 1'b0, d0, lat);
    checks++;
    if (lat != 17) begin errors++; $display("FAIL hold_latency: got %0d want 17", lat); end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL hold_done: got %b want 1", done); end
    checks++;
    if (Test_report !== 3'b100) begin errors++; $display("FAIL hold_report: got %b want 100", Test_report); end
    start_run(3'b100, 1'b0, d0, lat);
    checks++;
    if (d0 !== 1'b0) begin errors++; $display("FAIL relaunch_done_drop: got %b want 0", d0); end
    checks++;
    if (lat != 17) begin errors++; $display("FAIL relaunch_latency: got %0d want 17", lat); end
    checks++;
    if (Test_report !== 3'b100) begin errors++; $display("FAIL relaunch_report: got %b want 100", Test_report); end
  endtask

  initial begin
    test_reset();
    test_core();
    test_sll();
    test_all();
    test_fault();
    test_reset_mid_run();
    test_change_during_run();
    test_hold_relaunch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
